// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - clip, address and FIFO-buffer view pixels into the framebuffer write port
// Also runs a full-screen clear; clear_busy/clear_done are decodes of the registered state.
module pixel_fb_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [8:0]       X_in,
  input  logic [7:0]       Y_in,
  input  logic [11:0]      Color_in,
  input  logic             writeEn_in,
  input  logic             fb_ready,
  input  logic             clear_req,
  input  logic [11:0]      clear_color,
  input  logic             stats_clear,
  output logic [16:0]      fb_addr,
  output logic [11:0]      fb_data,
  output logic             fb_wren,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             fifo_full,
  output logic [CNT_W-1:0] clip_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT   = FIFO_DEPTH[AW:0];
  localparam logic [16:0]     LAST_ADDR  = 17'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t          state;
  logic [16:0]     mem_addr  [FIFO_DEPTH];
  logic [11:0]     mem_color [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [16:0]     clear_cnt;
  logic [11:0]     clear_color_q;

  logic            in_range, fifo_empty, pop, push, clip_inc, drop_inc;
  logic [16:0]     pix_addr;

  assign in_range   = (int'(X_in) < WIDTH) && (int'(Y_in) < HEIGHT);
  assign pix_addr   = 17'(int'(Y_in) * WIDTH + int'(X_in));
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  // A clear request wins over draining in the same cycle.
  assign pop        = (state == S_IDLE) && !clear_req && !fifo_empty && fb_ready;
  assign push       = writeEn_in && in_range && (!fifo_full || pop);
  assign clip_inc   = writeEn_in && !in_range;
  assign drop_inc   = writeEn_in && in_range && fifo_full && !pop;

  assign clear_busy = (state == S_CLEAR);
  assign clear_done = (state == S_DONE);

  // Storage is not reset; occupancy and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= pix_addr;
      mem_color[wr_ptr] <= Color_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      clear_cnt     <= '0;
      clear_color_q <= '0;
      fb_addr       <= '0;
      fb_data       <= '0;
      fb_wren       <= 1'b0;
      clip_count    <= '0;
      drop_count    <= '0;
    end else begin
      fb_wren <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            fb_addr <= mem_addr[rd_ptr];
            fb_data <= mem_color[rd_ptr];
            fb_wren <= 1'b1;
          end
          if (clear_req) begin
            state         <= S_CLEAR;
            clear_cnt     <= '0;
            clear_color_q <= clear_color;
          end
        end
        S_CLEAR: begin
          if (fb_ready) begin
            fb_addr   <= clear_cnt;
            fb_data   <= clear_color_q;
            fb_wren   <= 1'b1;
            clear_cnt <= clear_cnt + 1'b1;
            if (clear_cnt == LAST_ADDR) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (stats_clear)                    clip_count <= '0;
      else if (clip_inc && ~&clip_count)  clip_count <= clip_count + 1'b1;
      if (stats_clear)                    drop_count <= '0;
      else if (drop_inc && ~&drop_count)  drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb/tb_pixel_fb_writer.sv - directed and random checks of pixel_fb_writer against a queue model
module tb_pixel_fb_writer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  X_in;
  logic [7:0]  Y_in;
  logic [11:0] Color_in;
  logic        writeEn_in, fb_ready, clear_req, stats_clear;
  logic [11:0] clear_color;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_wren, clear_busy, clear_done, fifo_full;
  logic [15:0] clip_count, drop_count;

  pixel_fb_writer dut (
    .clk(clk), .resetn(resetn), .X_in(X_in), .Y_in(Y_in), .Color_in(Color_in),
    .writeEn_in(writeEn_in), .fb_ready(fb_ready), .clear_req(clear_req),
    .clear_color(clear_color), .stats_clear(stats_clear), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_wren(fb_wren), .clear_busy(clear_busy),
    .clear_done(clear_done), .fifo_full(fifo_full), .clip_count(clip_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int color;} pix_t;
  pix_t q[$];
  int   m_mode, m_cidx, m_ccol;
  int   e_wren, e_addr, e_data, e_clip, e_drop;
  int   n_tests = 0, n_fail = 0, n_wr = 0, n_done = 0;
  int   obs_addr[$];
  int   saved_drop;
  bit   done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_cidx = 0; m_ccol = 0;
    e_wren = 0; e_addr = 0; e_data = 0; e_clip = 0; e_drop = 0;
  endtask

  // Model mode: 0 idle/drain, 1 clearing, 2 clear finished.
  task automatic step();
    pix_t p;
    e_wren = 0;
    case (m_mode)
      0: begin
        if (!clear_req && q.size() > 0 && fb_ready) begin
          p = q.pop_front();
          e_wren = 1; e_addr = p.addr; e_data = p.color;
        end
        if (clear_req) begin
          m_mode = 1; m_ccol = clear_color; m_cidx = 0;
        end
      end
      1: if (fb_ready) begin
        e_wren = 1; e_addr = m_cidx; e_data = m_ccol;
        m_cidx++;
        if (m_cidx == 320 * 240) m_mode = 2;
      end
      default: m_mode = 0;
    endcase
    if (writeEn_in) begin
      if (X_in >= 320 || Y_in >= 240) begin
        if (e_clip < 65535) e_clip++;
      end else if (q.size() < 8) begin
        p.addr = Y_in * 320 + X_in; p.color = Color_in;
        q.push_back(p);
      end else if (e_drop < 65535) e_drop++;
    end
    if (stats_clear) begin e_clip = 0; e_drop = 0; end
    @(posedge clk); #1;
    if (fb_wren === 1'b1) begin n_wr++; obs_addr.push_back(int'(fb_addr)); end
    if (clear_done === 1'b1) n_done++;
    chk("fb_wren", fb_wren, e_wren);
    chk("fb_addr", fb_addr, e_addr);
    chk("fb_data", fb_data, e_data);
    chk("clear_busy", clear_busy, m_mode == 1);
    chk("clear_done", clear_done, m_mode == 2);
    chk("fifo_full", fifo_full, q.size() == 8);
    chk("clip_count", clip_count, e_clip);
    chk("drop_count", drop_count, e_drop);
  endtask

  task automatic pix(input int x, input int y, input int c);
    writeEn_in = 1'b1; X_in = 9'(x); Y_in = 8'(y); Color_in = 12'(c);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, fb_addr, 0);
    chk({tag, "_data"}, fb_data, 0);
    chk({tag, "_wren"}, fb_wren, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_clip"}, clip_count, 0);
    chk({tag, "_drop"}, drop_count, 0);
  endtask

  initial begin
    resetn = 1'b0; X_in = '0; Y_in = '0; Color_in = '0; writeEn_in = 1'b0;
    fb_ready = 1'b0; clear_req = 1'b0; clear_color = '0; stats_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;

    // 1: single pixel latency and address
    fb_ready = 1'b1;
    pix(5, 2, 12'hF00); step();
    writeEn_in = 1'b0;
    chk("t1_no_early_wren", fb_wren, 0);
    step();
    chk("t1_wren", fb_wren, 1);
    chk("t1_addr", fb_addr, 645);
    chk("t1_data", fb_data, 12'hF00);
    step();
    chk("t1_single_pulse", fb_wren, 0);

    // 2: clipping and stats_clear
    n_wr = 0;
    pix(320, 0, 1); step();
    pix(0, 240, 2); step();
    writeEn_in = 1'b0; step(); step();
    chk("t2_no_writes", n_wr, 0);
    chk("t2_clip", clip_count, 2);
    stats_clear = 1'b1; step(); stats_clear = 1'b0;
    chk("t2_clip_cleared", clip_count, 0);

    // 3: overflow drops then in-order drain
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin pix(i, 10, 12'h100 + i); step(); end
    writeEn_in = 1'b0;
    chk("t3_full", fifo_full, 1);
    chk("t3_drop", drop_count, 2);
    obs_addr.delete();
    fb_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("t3_nwrites", obs_addr.size(), 8);
    for (int i = 0; i < 8 && i < obs_addr.size(); i++)
      chk("t3_order", obs_addr[i], 10 * 320 + i);

    // 4: full FIFO with simultaneous push and pop never drops
    stats_clear = 1'b1; step(); stats_clear = 1'b0;
    fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin pix(i, 20, i); step(); end
    fb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix($urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 4095));
      step();
      chk("t4_full_held", fifo_full, 1);
    end
    chk("t4_no_drop", drop_count, 0);
    writeEn_in = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      writeEn_in  = 1'($urandom_range(0, 1));
      X_in        = 9'($urandom_range(0, 335));
      Y_in        = 8'($urandom_range(0, 250));
      Color_in    = 12'($urandom);
      fb_ready    = ($urandom_range(0, 3) != 0);
      stats_clear = ($urandom_range(0, 63) == 0);
      step();
    end
    writeEn_in = 1'b0; stats_clear = 1'b0; fb_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // 5: full-screen clear with pixels arriving mid-clear
    clear_color = 12'h00F; clear_req = 1'b1; step(); clear_req = 1'b0;
    n_wr = 0; n_done = 0; done_seen = 1'b0;
    for (int i = 0; i < 77000 && !done_seen; i++) begin
      if (i < 3) pix(i + 1, 1, 12'hABC); else writeEn_in = 1'b0;
      step();
      if (clear_done === 1'b1) done_seen = 1'b1;
    end
    chk("t5_done_seen", done_seen, 1);
    chk("t5_clear_writes", n_wr, 320 * 240);
    n_wr = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_done_once", n_done, 1);
    chk("t5_pixel_writes", n_wr, 3);

    // 6: reset in the middle of a clear with queued pixels
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int i = 0; i < 4; i++) begin pix(i, 30, 12'h0F0); step(); end
    writeEn_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 resetn = 1'b0;
    #1 chk_all_zero("t6_reset");
    model_reset();
    @(posedge clk); #1 resetn = 1'b1;
    n_wr = 0; n_done = 0;
    for (int i = 0; i < 20; i++) step();
    chk("t6_no_writes", n_wr, 0);
    chk("t6_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
